blake_msg_buffer: RTL and testbench
===================================

// Module: blake_msg_buffer
// PURPOSE
//  Downstream of the BLAKE host interface. Assembles the 32-bit words strobed out by Ld_EN into one
//  16-word (512-bit) message block, tagged with the 64-bit bit counter t. Double-buffered: a fill
//  buffer collects the next block while the issue buffer holds the block offered to the
//  compression core. Drives the interface's busy input.
// PARAMETERS
//  NWORDS   16  words per message block
//  WORD_W   32  word width (bits)
//  CNT_W    64  counter t width (bits)
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  init        in   1               synchronous clear of all state (new message)
//  ld_en       in   1               word strobe; idata32 valid this cycle
//  idata32     in   WORD_W          message word, first word of the block arrives first
//  counter     in   CNT_W           bit counter t for the block being loaded
//  start       in   1               request: move the full fill buffer to issue buffer
//  core_ready  in   1               core accepts issued block when high with blk_valid
//  m_block     out  NWORDS*WORD_W   issued block; word0 at [511:480], word15 at [31:0]
//  t_out       out  CNT_W           counter captured with the issued block
//  blk_valid   out  1               issue buffer holds an unaccepted block
//  busy        out  1               to interface busy: fill full, swap pending, or blk_valid
//  wcount      out  5               words in fill buffer, 0..16
//  ovf_err     out  1               sticky: ld_en while fill buffer full
//  start_err   out  1               sticky: start while fill buffer not full
// BEHAVIOUR
//  Reset (rst_n=0, async): m_block=0, t_out=0, blk_valid=0, wcount=0, pend=0, ovf_err=0,
//   start_err=0, busy=0. init=1 (sync) clears the same state. init beats every other input in
//   the same cycle.
//  Fill: ld_en && wcount<16 -> fill[wcount]<=idata32, wcount++ (registered, 1 cycle).
//   wcount==16 means full. ld_en at full -> word dropped, ovf_err<=1, wcount unchanged.
//  Start: start && wcount==16 -> pend<=1. start && wcount<16 -> ignored, start_err<=1.
//   start while pend is already 1 -> no effect.
//  Swap: condition is pend && (!blk_valid || accept), where accept=blk_valid&&core_ready.
//   When it holds, the next edge loads m_block<=fill, t_out<=counter (sampled on that edge),
//   blk_valid<=1, wcount<=0, pend<=0. A swap on the accept cycle keeps blk_valid at 1 with no
//   bubble.
//  ld_en on the swap cycle: dropped, because wcount is still 16; ovf_err<=1.
//  Accept without swap: blk_valid<=0. m_block and t_out hold their last value.
//  Issue buffer stays stable while blk_valid && !core_ready.
//  busy = (wcount==16) | pend | blk_valid. busy is combinational from registers only.
//  No combinational path from any input to any output.
//  State summary (fill side): EMPTY(0) -> FILLING(1..15) -> FULL(16) -> PEND -> EMPTY on swap.
// TESTING
//  1 Reset mid-fill: 7 ld_en, rst_n low -> wcount=0, blk_valid=0, busy=0; start -> start_err=1.
//  2 Fill words 0x00000000..0x0000000F, counter=512, start, core_ready=1
//     -> 1 cycle later blk_valid=1, m_block[511:480]=0, m_block[31:0]=0xF, t_out=512.
//     -> blk_valid=0 one cycle after that.
//  3 Backpressure: core_ready=0, second block filled and started -> pend=1, busy=1.
//     Raise core_ready -> second block issued on the accept edge, blk_valid stays 1, t updated.
//  4 17th ld_en with fill full -> word dropped, ovf_err=1, fill contents unchanged.
//  5 start at wcount=15 -> no swap, start_err=1; 16th word + start -> normal issue.
//  6 init with blk_valid=1, pend=1 -> all cleared next cycle, busy=0, sticky errors cleared.

Source files
------------

// File: rtl/blake_msg_buffer_if.sv
// Bundles the host-side word stream and the issue-side block handshake of the BLAKE message buffer.
// Latency: none (wiring only).
// Backpressure: core_ready/blk_valid on the issue side; busy tells the host to stop strobing.
interface blake_msg_buffer_if #(
    parameter int NWORDS = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 64
);
    logic                     init;
    logic                     ld_en;
    logic [WORD_W-1:0]        idata32;
    logic [CNT_W-1:0]         counter;
    logic                     start;
    logic                     core_ready;
    logic [NWORDS*WORD_W-1:0] m_block;
    logic [CNT_W-1:0]         t_out;
    logic                     blk_valid;
    logic                     busy;
    logic [4:0]               wcount;
    logic                     ovf_err;
    logic                     start_err;

    // Host / core side: drives the word stream and the accept strobe, observes status.
    modport master (
        output init, ld_en, idata32, counter, start, core_ready,
        input  m_block, t_out, blk_valid, busy, wcount, ovf_err, start_err
    );

    // Buffer side.
    modport slave (
        input  init, ld_en, idata32, counter, start, core_ready,
        output m_block, t_out, blk_valid, busy, wcount, ovf_err, start_err
    );
endinterface

// File: rtl/blake_msg_buffer.sv
// Double-buffered BLAKE message block assembler: fill buffer collects 16 words, issue buffer offers them.
// Latency: word stored 1 cycle after ld_en; block issued 1 cycle after start registers (pend), 2 from start.
// Backpressure: issue buffer holds while blk_valid && !core_ready; busy stalls the host when full/pending/issued.
module blake_msg_buffer #(
    parameter int NWORDS = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic clk,
    input  logic rst_n,
    blake_msg_buffer_if.slave bus
);
    logic [WORD_W-1:0]        fill [NWORDS];
    logic [NWORDS*WORD_W-1:0] fill_flat;
    logic [NWORDS*WORD_W-1:0] m_block;
    logic [CNT_W-1:0]         t_out;
    logic                     blk_valid;
    logic [4:0]               wcount;
    logic                     pend;
    logic                     ovf_err;
    logic                     start_err;

    logic full;
    logic accept;
    logic swap;
    logic store;

    assign full   = (wcount == 5'd16);
    assign accept = blk_valid & bus.core_ready;
    // pend is only ever set while full, so a swap always moves a complete block.
    assign swap   = pend & (~blk_valid | accept);
    assign store  = bus.ld_en & ~full & ~bus.init;

    // Flatten the fill buffer so word0 lands in the most significant slot.
    always_comb begin
        fill_flat = '0;
        for (int i = 0; i < NWORDS; i++) begin
            fill_flat[(NWORDS-1-i)*WORD_W +: WORD_W] = fill[i];
        end
    end

    // Fill buffer storage; contents are only meaningful below wcount, so no reset is needed.
    always_ff @(posedge clk) begin
        if (store) begin
            fill[wcount[3:0]] <= bus.idata32;
        end
    end

    // Control and issue-buffer state; a swap takes priority over the fill-side updates it would conflict with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_block   <= '0;
            t_out     <= '0;
            blk_valid <= 1'b0;
            wcount    <= 5'd0;
            pend      <= 1'b0;
            ovf_err   <= 1'b0;
            start_err <= 1'b0;
        end else if (bus.init) begin
            m_block   <= '0;
            t_out     <= '0;
            blk_valid <= 1'b0;
            wcount    <= 5'd0;
            pend      <= 1'b0;
            ovf_err   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            if (swap) begin
                m_block   <= fill_flat;
                t_out     <= bus.counter;
                blk_valid <= 1'b1;
                wcount    <= 5'd0;
                pend      <= 1'b0;
            end else begin
                if (accept) begin
                    blk_valid <= 1'b0;
                end
                if (bus.start && full) begin
                    pend <= 1'b1;
                end
                if (bus.ld_en && !full) begin
                    wcount <= wcount + 5'd1;
                end
            end
            // Words arriving at full (including the swap cycle) are dropped and flagged.
            if (bus.ld_en && full) begin
                ovf_err <= 1'b1;
            end
            if (bus.start && !full) begin
                start_err <= 1'b1;
            end
        end
    end

    assign bus.m_block   = m_block;
    assign bus.t_out     = t_out;
    assign bus.blk_valid = blk_valid;
    assign bus.wcount    = wcount;
    assign bus.ovf_err   = ovf_err;
    assign bus.start_err = start_err;
    assign bus.busy      = full | pend | blk_valid;
endmodule

// File: tb/tb_blake_msg_buffer.sv
// Directed bench for blake_msg_buffer: fill, issue, backpressure, overflow, early start, init.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the following edge.
// Backpressure: core_ready is driven by the bench to hold or release the issue buffer.
module tb_blake_msg_buffer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    blake_msg_buffer_if #(.NWORDS(16), .WORD_W(32), .CNT_W(64)) bif ();

    blake_msg_buffer #(.NWORDS(16), .WORD_W(32), .CNT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_block(input logic [31:0] base);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            b[(15-i)*32 +: 32] = base + 32'(i);
        end
        return b;
    endfunction

    task automatic load_words(input logic [31:0] base, input int n, input logic [63:0] cnt);
        for (int i = 0; i < n; i++) begin
            bif.ld_en   = 1'b1;
            bif.idata32 = base + 32'(i);
            bif.counter = cnt;
            step();
        end
        bif.ld_en = 1'b0;
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n          = 1'b0;
        bif.init       = 1'b0;
        bif.ld_en      = 1'b0;
        bif.idata32    = '0;
        bif.counter    = '0;
        bif.start      = 1'b0;
        bif.core_ready = 1'b0;
        step();
        step();
        chk("rst_wcount",    512'(bif.wcount),    512'd0);
        chk("rst_blk_valid", 512'(bif.blk_valid), 512'd0);
        chk("rst_busy",      512'(bif.busy),      512'd0);
        chk("rst_m_block",   bif.m_block,         512'd0);
        chk("rst_t_out",     512'(bif.t_out),     512'd0);
        chk("rst_errs",      512'({bif.ovf_err, bif.start_err}), 512'd0);

        // 1: reset mid-fill, then an early start.
        rst_n = 1'b1;
        step();
        load_words(32'h0, 7, 64'd0);
        chk("t1_wcount7", 512'(bif.wcount), 512'd7);
        rst_n = 1'b0;
        #2;
        chk("t1_async_wcount", 512'(bif.wcount), 512'd0);
        chk("t1_async_busy",   512'(bif.busy),   512'd0);
        rst_n = 1'b1;
        step();
        pulse_start();
        chk("t1_start_err", 512'(bif.start_err), 512'd1);
        chk("t1_no_issue",  512'(bif.blk_valid), 512'd0);
        bif.init = 1'b1;
        step();
        bif.init = 1'b0;
        chk("t1_init_clr", 512'(bif.start_err), 512'd0);

        // 2: simple block with the core ready.
        bif.core_ready = 1'b1;
        load_words(32'h0, 16, 64'd512);
        chk("t2_full",      512'(bif.wcount), 512'd16);
        chk("t2_busy_full", 512'(bif.busy),   512'd1);
        pulse_start();
        chk("t2_pend_noval", 512'(bif.blk_valid), 512'd0);
        chk("t2_pend_busy",  512'(bif.busy),      512'd1);
        step();
        chk("t2_valid",   512'(bif.blk_valid),      512'd1);
        chk("t2_word0",   512'(bif.m_block[511:480]), 512'd0);
        chk("t2_word15",  512'(bif.m_block[31:0]),  512'h0000000F);
        chk("t2_block",   bif.m_block,              mk_block(32'h0));
        chk("t2_t_out",   512'(bif.t_out),          512'd512);
        chk("t2_wcount0", 512'(bif.wcount),         512'd0);
        step();
        chk("t2_accepted", 512'(bif.blk_valid), 512'd0);
        chk("t2_hold",     bif.m_block,         mk_block(32'h0));
        chk("t2_idle",     512'(bif.busy),      512'd0);

        // 3: backpressure with a second block pending behind the first.
        bif.core_ready = 1'b0;
        load_words(32'h100, 16, 64'd1024);
        pulse_start();
        step();
        chk("t3_b1_valid", 512'(bif.blk_valid), 512'd1);
        chk("t3_b1_t",     512'(bif.t_out),     512'd1024);
        load_words(32'h200, 16, 64'd1536);
        pulse_start();
        step();
        chk("t3_stall_valid", 512'(bif.blk_valid), 512'd1);
        chk("t3_stall_block", bif.m_block,          mk_block(32'h100));
        chk("t3_stall_t",     512'(bif.t_out),      512'd1024);
        chk("t3_stall_busy",  512'(bif.busy),       512'd1);
        chk("t3_stall_full",  512'(bif.wcount),     512'd16);
        bif.core_ready = 1'b1;
        step();
        chk("t3_b2_valid", 512'(bif.blk_valid), 512'd1);
        chk("t3_b2_block", bif.m_block,         mk_block(32'h200));
        chk("t3_b2_t",     512'(bif.t_out),     512'd1536);
        chk("t3_b2_empty", 512'(bif.wcount),    512'd0);
        step();
        chk("t3_drained", 512'(bif.blk_valid), 512'd0);

        // 4: overflow word dropped without disturbing the fill buffer.
        load_words(32'h300, 16, 64'd2048);
        bif.ld_en   = 1'b1;
        bif.idata32 = 32'hDEADBEEF;
        step();
        bif.ld_en = 1'b0;
        chk("t4_ovf",    512'(bif.ovf_err), 512'd1);
        chk("t4_wcount", 512'(bif.wcount),  512'd16);
        bif.core_ready = 1'b0;
        pulse_start();
        step();
        chk("t4_block", bif.m_block,     mk_block(32'h300));
        chk("t4_t",     512'(bif.t_out), 512'd2048);
        bif.core_ready = 1'b1;
        step();
        chk("t4_drained", 512'(bif.blk_valid), 512'd0);

        // 5: start one word early is rejected, then a proper start issues.
        bif.init = 1'b1;
        step();
        bif.init = 1'b0;
        load_words(32'h400, 15, 64'd2560);
        pulse_start();
        chk("t5_start_err", 512'(bif.start_err), 512'd1);
        step();
        chk("t5_no_issue", 512'(bif.blk_valid), 512'd0);
        chk("t5_wcount15", 512'(bif.wcount),    512'd15);
        bif.ld_en   = 1'b1;
        bif.idata32 = 32'h40F;
        step();
        bif.ld_en = 1'b0;
        pulse_start();
        step();
        chk("t5_valid", 512'(bif.blk_valid), 512'd1);
        chk("t5_block", bif.m_block,         mk_block(32'h400));
        chk("t5_t",     512'(bif.t_out),     512'd2560);
        bif.core_ready = 1'b0;

        // 6: init wipes an issued block, a pending swap and both sticky errors.
        load_words(32'h500, 17, 64'd3072);
        pulse_start();
        chk("t6_pre_valid", 512'(bif.blk_valid), 512'd1);
        chk("t6_pre_ovf",   512'(bif.ovf_err),   512'd1);
        bif.init = 1'b1;
        bif.start = 1'b1;
        bif.ld_en = 1'b1;
        step();
        bif.init  = 1'b0;
        bif.start = 1'b0;
        bif.ld_en = 1'b0;
        chk("t6_valid",  512'(bif.blk_valid), 512'd0);
        chk("t6_busy",   512'(bif.busy),      512'd0);
        chk("t6_wcount", 512'(bif.wcount),    512'd0);
        chk("t6_block",  bif.m_block,         512'd0);
        chk("t6_t",      512'(bif.t_out),     512'd0);
        chk("t6_errs",   512'({bif.ovf_err, bif.start_err}), 512'd0);
        step();
        chk("t6_no_swap", 512'(bif.blk_valid), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
